// File: rtl/dmem_responder_if.sv
// Request/response channel between the memory stage and the data-memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM with programmable wait states and one outstanding request.
// state   | meaning
// IDLE    | ready for a request; with zero wait states the access happens at acceptance
// WAIT    | request latched, counting down wait states; access when counter reaches 1
// RESP    | response registered and presented until resp_ready is sampled
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_in_idle;
  logic             w_accept;
  logic             w_access;
  logic             w_write;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic [3:0]       w_be;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;

  // In IDLE the access (zero wait states) uses the live request, otherwise the latched copy.
  assign w_in_idle = (r_state == ST_IDLE);
  assign w_accept  = w_in_idle && bus.req_valid;
  assign w_access  = reset && ((WAIT_CYCLES == 0) ? w_accept
                                                  : ((r_state == ST_WAIT) && (r_cnt == 4'd1)));
  assign w_write   = w_in_idle ? bus.req_write : r_write;
  assign w_addr    = w_in_idle ? bus.req_addr  : r_addr;
  assign w_wdata   = w_in_idle ? bus.req_wdata : r_wdata;
  assign w_be      = w_in_idle ? bus.req_be    : r_be;
  assign w_err     = (w_addr[1:0] != 2'b00) || (w_addr[31:2] >= 30'(DEPTH_WORDS));
  assign w_idx     = w_addr[IDX_W+1:2];

  assign bus.req_ready  = reset && w_in_idle;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_be         <= 4'd0;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'd0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_be    <= bus.req_be;
            if (WAIT_CYCLES == 0) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_cnt   <= WAIT_LOAD;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_access) begin
        r_rdata <= (!w_err && !w_write) ? r_mem[w_idx] : 32'd0;
        r_err   <= w_err;
      end
    end
  end

  // RAM is deliberately not reset; committed stores survive a reset.
  always_ff @(posedge clk) begin
    if (w_access && w_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end
endmodule
